// File: rtl/ysyx_24100006_axi_arbiter_pkg.sv
// Shared definitions for the IFU/LSU AXI arbiter: FSM encoding, AXI constants
// and the saturating watchdog increment.
package ysyx_24100006_axi_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_IFU_R = 2'd1,
    S_LSU_R = 2'd2,
    S_LSU_W = 2'd3
  } arb_state_e;

  localparam logic [2:0] AXI_SIZE_B    = 3'd0;
  localparam logic [2:0] AXI_SIZE_H    = 3'd1;
  localparam logic [2:0] AXI_SIZE_W    = 3'd2;
  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [1:0] AXI_RESP_SLV  = 2'b10;
  localparam logic [1:0] AXI_RESP_DEC  = 2'b11;

  function automatic logic [31:0] cnt_next(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

endpackage

// File: rtl/ysyx_24100006_arb_pick.sv
// Two-way requester pick between IFU and the LSU (read/write pair counts as one).
// Fixed priority favours LSU; round-robin alternates on conflict using last_lsu.
module ysyx_24100006_arb_pick #(
  parameter bit RR_EN = 1'b0
) (
  input  logic ifu_req,
  input  logic lsu_req,
  input  logic last_lsu,
  output logic grant_ifu,
  output logic grant_lsu
);

  logic lsu_wins;

  always_comb begin
    if (ifu_req && lsu_req) begin
      lsu_wins = RR_EN ? !last_lsu : 1'b1;
    end else begin
      lsu_wins = lsu_req;
    end
  end

  assign grant_lsu = lsu_wins;
  assign grant_ifu = ifu_req & ~lsu_wins;

endmodule

// File: rtl/ysyx_24100006_axi_arbiter.sv
// 2:1 AXI4 master arbiter: IFU (read) and LSU (read+write) share one slave port,
// one whole transaction at a time, with an optional per-transaction watchdog.
module ysyx_24100006_axi_arbiter
  import ysyx_24100006_axi_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RR_EN  = 0,
  parameter int TO_CYC = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [7:0]          ifu_arlen,
  input  logic [2:0]          ifu_arsize,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic                ifu_rlast,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic [7:0]          lsu_arlen,
  input  logic [2:0]          lsu_arsize,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic                lsu_rlast,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [7:0]          lsu_awlen,
  input  logic [2:0]          lsu_awsize,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  input  logic                lsu_wlast,
  output logic [1:0]          lsu_bresp,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [ADDR_W-1:0]   s_araddr,
  output logic                s_arvalid,
  input  logic                s_arready,
  output logic [7:0]          s_arlen,
  output logic [2:0]          s_arsize,
  input  logic [DATA_W-1:0]   s_rdata,
  input  logic [1:0]          s_rresp,
  input  logic                s_rvalid,
  output logic                s_rready,
  input  logic                s_rlast,
  output logic [ADDR_W-1:0]   s_awaddr,
  output logic                s_awvalid,
  input  logic                s_awready,
  output logic [7:0]          s_awlen,
  output logic [2:0]          s_awsize,
  output logic [DATA_W-1:0]   s_wdata,
  output logic [DATA_W/8-1:0] s_wstrb,
  output logic                s_wvalid,
  input  logic                s_wready,
  output logic                s_wlast,
  input  logic [1:0]          s_bresp,
  input  logic                s_bvalid,
  output logic                s_bready,
  output logic                arb_busy,
  output logic                arb_timeout
);

  localparam logic [31:0] TO_LIM = (TO_CYC > 0) ? 32'(TO_CYC - 1) : 32'd0;

  arb_state_e  state;
  logic        last_lsu;
  logic [31:0] cnt;
  logic        addr_sent;
  logic        w_sent;
  logic        grant_ifu, grant_lsu;
  logic        ifu_sel, lsu_r_sel, lsu_w_sel, ar_open, w_open;
  logic        addr_hs, w_hs, txn_end;

  ysyx_24100006_arb_pick #(.RR_EN(RR_EN != 0)) u_pick (
    .ifu_req   (ifu_arvalid),
    .lsu_req   (lsu_arvalid | lsu_awvalid),
    .last_lsu  (last_lsu),
    .grant_ifu (grant_ifu),
    .grant_lsu (grant_lsu)
  );

  assign ifu_sel   = (state == S_IFU_R);
  assign lsu_r_sel = (state == S_LSU_R);
  assign lsu_w_sel = (state == S_LSU_W);
  // Address/last-W are blocked once accepted so a master's next request cannot slip in.
  assign ar_open   = (ifu_sel | lsu_r_sel) & ~addr_sent;
  assign w_open    = lsu_w_sel & ~w_sent;

  assign s_araddr  = ifu_sel ? ifu_araddr : (lsu_r_sel ? lsu_araddr : '0);
  assign s_arlen   = ifu_sel ? ifu_arlen  : (lsu_r_sel ? lsu_arlen  : 8'd0);
  assign s_arsize  = ifu_sel ? ifu_arsize : (lsu_r_sel ? lsu_arsize : 3'd0);
  assign s_arvalid = ar_open & (ifu_sel ? ifu_arvalid : lsu_arvalid);
  assign ifu_arready = ifu_sel & ~addr_sent & s_arready;
  assign lsu_arready = lsu_r_sel & ~addr_sent & s_arready;

  assign ifu_rdata  = ifu_sel ? s_rdata : '0;
  assign ifu_rresp  = ifu_sel ? s_rresp : 2'b00;
  assign ifu_rvalid = ifu_sel & s_rvalid;
  assign ifu_rlast  = ifu_sel & s_rlast;
  assign lsu_rdata  = lsu_r_sel ? s_rdata : '0;
  assign lsu_rresp  = lsu_r_sel ? s_rresp : 2'b00;
  assign lsu_rvalid = lsu_r_sel & s_rvalid;
  assign lsu_rlast  = lsu_r_sel & s_rlast;
  assign s_rready   = (ifu_sel & ifu_rready) | (lsu_r_sel & lsu_rready);

  assign s_awaddr    = lsu_w_sel ? lsu_awaddr : '0;
  assign s_awlen     = lsu_w_sel ? lsu_awlen  : 8'd0;
  assign s_awsize    = lsu_w_sel ? lsu_awsize : 3'd0;
  assign s_awvalid   = lsu_w_sel & ~addr_sent & lsu_awvalid;
  assign lsu_awready = lsu_w_sel & ~addr_sent & s_awready;
  assign s_wdata     = lsu_w_sel ? lsu_wdata : '0;
  assign s_wstrb     = lsu_w_sel ? lsu_wstrb : '0;
  assign s_wlast     = lsu_w_sel & lsu_wlast;
  assign s_wvalid    = w_open & lsu_wvalid;
  assign lsu_wready  = w_open & s_wready;
  assign lsu_bresp   = lsu_w_sel ? s_bresp : 2'b00;
  assign lsu_bvalid  = lsu_w_sel & s_bvalid;
  assign s_bready    = lsu_w_sel & lsu_bready;

  assign addr_hs  = (s_arvalid & s_arready) | (s_awvalid & s_awready);
  assign w_hs     = s_wvalid & s_wready;
  assign txn_end  = ((ifu_sel | lsu_r_sel) & s_rvalid & s_rready & s_rlast) |
                    (lsu_w_sel & s_bvalid & s_bready);
  assign arb_busy = (state != S_IDLE);

  // Grant FSM, round-robin history, watchdog and per-transaction channel bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      last_lsu    <= 1'b0;
      cnt         <= 32'd0;
      arb_timeout <= 1'b0;
      addr_sent   <= 1'b0;
      w_sent      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt       <= 32'd0;
          addr_sent <= 1'b0;
          w_sent    <= 1'b0;
          if (grant_lsu) begin
            state    <= lsu_arvalid ? S_LSU_R : S_LSU_W;
            last_lsu <= 1'b1;
          end else if (grant_ifu) begin
            state    <= S_IFU_R;
            last_lsu <= 1'b0;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          if (addr_hs) addr_sent <= 1'b1;
          if (w_hs && s_wlast) w_sent <= 1'b1;
          if (txn_end) begin
            state <= S_IDLE;
          end else if ((TO_CYC != 0) && (cnt == TO_LIM)) begin
            arb_timeout <= 1'b1;
            state       <= S_IDLE;
          end else begin
            cnt <= cnt_next(cnt);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_axi_arbiter.sv
// Directed bench: u_fix (fixed priority, 16-cycle watchdog) and u_rr (round-robin)
// share master-side stimulus; each has its own slave-side drive.
module tb_ysyx_24100006_axi_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] ifu_araddr = '0, lsu_araddr = '0, lsu_awaddr = '0, lsu_wdata = '0;
  logic        ifu_arvalid = 0, ifu_rready = 0, lsu_arvalid = 0, lsu_rready = 0;
  logic        lsu_awvalid = 0, lsu_wvalid = 0, lsu_wlast = 0, lsu_bready = 0;
  logic [7:0]  ifu_arlen = '0, lsu_arlen = '0, lsu_awlen = '0;
  logic [2:0]  ifu_arsize = '0, lsu_arsize = '0, lsu_awsize = '0;
  logic [3:0]  lsu_wstrb = '0;

  logic [31:0] s_rdata = '0, r_s_rdata = '0;
  logic [1:0]  s_rresp = '0, s_bresp = '0, r_s_rresp = '0, r_s_bresp = '0;
  logic        s_arready = 0, s_rvalid = 0, s_rlast = 0, s_awready = 0, s_wready = 0, s_bvalid = 0;
  logic        r_s_arready = 0, r_s_rvalid = 0, r_s_rlast = 0, r_s_awready = 0, r_s_wready = 0, r_s_bvalid = 0;

  logic [31:0] ifu_rdata, lsu_rdata, s_araddr, s_awaddr, s_wdata;
  logic [1:0]  ifu_rresp, lsu_rresp, lsu_bresp;
  logic        ifu_arready, ifu_rvalid, ifu_rlast, lsu_arready, lsu_rvalid, lsu_rlast;
  logic        lsu_awready, lsu_wready, lsu_bvalid, s_arvalid, s_rready, s_awvalid;
  logic        s_wvalid, s_wlast, s_bready, arb_busy, arb_timeout;
  logic [7:0]  s_arlen, s_awlen;
  logic [2:0]  s_arsize, s_awsize;
  logic [3:0]  s_wstrb;

  logic [31:0] r_ifu_rdata, r_lsu_rdata, r_s_araddr, r_s_awaddr, r_s_wdata;
  logic [1:0]  r_ifu_rresp, r_lsu_rresp, r_lsu_bresp;
  logic        r_ifu_arready, r_ifu_rvalid, r_ifu_rlast, r_lsu_arready, r_lsu_rvalid, r_lsu_rlast;
  logic        r_lsu_awready, r_lsu_wready, r_lsu_bvalid, r_s_arvalid, r_s_rready, r_s_awvalid;
  logic        r_s_wvalid, r_s_wlast, r_s_bready, r_arb_busy, r_arb_timeout;
  logic [7:0]  r_s_arlen, r_s_awlen;
  logic [2:0]  r_s_arsize, r_s_awsize;
  logic [3:0]  r_s_wstrb;

  ysyx_24100006_axi_arbiter #(.RR_EN(0), .TO_CYC(16)) u_fix (
    .clk(clk), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
    .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rlast(ifu_rlast),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
    .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rlast(lsu_rlast),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(lsu_awready),
    .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(lsu_wready), .lsu_wlast(lsu_wlast),
    .lsu_bresp(lsu_bresp), .lsu_bvalid(lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid),
    .s_rready(s_rready), .s_rlast(s_rlast), .s_awaddr(s_awaddr), .s_awvalid(s_awvalid),
    .s_awready(s_awready), .s_awlen(s_awlen), .s_awsize(s_awsize), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wlast(s_wlast),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .arb_busy(arb_busy), .arb_timeout(arb_timeout)
  );

  ysyx_24100006_axi_arbiter #(.RR_EN(1), .TO_CYC(0)) u_rr (
    .clk(clk), .reset(reset),
    .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(r_ifu_arready),
    .ifu_arlen(ifu_arlen), .ifu_arsize(ifu_arsize), .ifu_rdata(r_ifu_rdata), .ifu_rresp(r_ifu_rresp),
    .ifu_rvalid(r_ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rlast(r_ifu_rlast),
    .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(r_lsu_arready),
    .lsu_arlen(lsu_arlen), .lsu_arsize(lsu_arsize), .lsu_rdata(r_lsu_rdata), .lsu_rresp(r_lsu_rresp),
    .lsu_rvalid(r_lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rlast(r_lsu_rlast),
    .lsu_awaddr(lsu_awaddr), .lsu_awvalid(lsu_awvalid), .lsu_awready(r_lsu_awready),
    .lsu_awlen(lsu_awlen), .lsu_awsize(lsu_awsize), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_wvalid(lsu_wvalid), .lsu_wready(r_lsu_wready), .lsu_wlast(lsu_wlast),
    .lsu_bresp(r_lsu_bresp), .lsu_bvalid(r_lsu_bvalid), .lsu_bready(lsu_bready),
    .s_araddr(r_s_araddr), .s_arvalid(r_s_arvalid), .s_arready(r_s_arready), .s_arlen(r_s_arlen),
    .s_arsize(r_s_arsize), .s_rdata(r_s_rdata), .s_rresp(r_s_rresp), .s_rvalid(r_s_rvalid),
    .s_rready(r_s_rready), .s_rlast(r_s_rlast), .s_awaddr(r_s_awaddr), .s_awvalid(r_s_awvalid),
    .s_awready(r_s_awready), .s_awlen(r_s_awlen), .s_awsize(r_s_awsize), .s_wdata(r_s_wdata),
    .s_wstrb(r_s_wstrb), .s_wvalid(r_s_wvalid), .s_wready(r_s_wready), .s_wlast(r_s_wlast),
    .s_bresp(r_s_bresp), .s_bvalid(r_s_bvalid), .s_bready(r_s_bready),
    .arb_busy(r_arb_busy), .arb_timeout(r_arb_timeout)
  );

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_lsu;

  initial begin
    // Reset
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_busy", 64'(arb_busy), 64'(1'b0));
    chk("rst_timeout", 64'(arb_timeout), 64'(1'b0));
    chk("rst_s_arvalid", 64'(s_arvalid), 64'(1'b0));

    // IFU lone single-beat read
    s_arready = 1'b1;
    ifu_araddr = 32'h8000_0000; ifu_arvalid = 1'b1; ifu_arlen = 8'd0; ifu_arsize = 3'd2;
    ifu_rready = 1'b1; lsu_rready = 1'b1;
    #1;
    chk("idle_ifu_arready", 64'(ifu_arready), 64'(1'b0));
    chk("idle_s_arvalid", 64'(s_arvalid), 64'(1'b0));
    tick(); #1;
    chk("t1_s_arvalid", 64'(s_arvalid), 64'(1'b1));
    chk("t1_s_araddr", 64'(s_araddr), 64'(32'h8000_0000));
    chk("t1_ifu_arready", 64'(ifu_arready), 64'(1'b1));
    chk("t1_busy", 64'(arb_busy), 64'(1'b1));
    tick();
    ifu_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'hDEAD_BEEF; s_rlast = 1'b1;
    #1;
    chk("t1_ifu_rvalid", 64'(ifu_rvalid), 64'(1'b1));
    chk("t1_ifu_rdata", 64'(ifu_rdata), 64'(32'hDEAD_BEEF));
    chk("t1_lsu_rvalid", 64'(lsu_rvalid), 64'(1'b0));
    chk("t1_lsu_rdata", 64'(lsu_rdata), 64'(32'h0));
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    chk("t1_idle_busy", 64'(arb_busy), 64'(1'b0));

    // IFU + LSU read in the same cycle: LSU first
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0010;
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_1000;
    tick(); #1;
    chk("t2_lsu_arready", 64'(lsu_arready), 64'(1'b1));
    chk("t2_ifu_arready", 64'(ifu_arready), 64'(1'b0));
    chk("t2_s_araddr", 64'(s_araddr), 64'(32'h0000_1000));
    tick();
    lsu_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h1234_5678; s_rlast = 1'b1;
    #1;
    chk("t2_lsu_rvalid", 64'(lsu_rvalid), 64'(1'b1));
    chk("t2_lsu_rdata", 64'(lsu_rdata), 64'(32'h1234_5678));
    chk("t2_ifu_rvalid", 64'(ifu_rvalid), 64'(1'b0));
    chk("t2_ifu_arready_wait", 64'(ifu_arready), 64'(1'b0));
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    chk("t2_bubble_ifu_arready", 64'(ifu_arready), 64'(1'b0));
    tick(); #1;
    chk("t2_ifu_arready", 64'(ifu_arready), 64'(1'b1));
    chk("t2_s_araddr_ifu", 64'(s_araddr), 64'(32'h8000_0010));
    tick();
    ifu_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h0BAD_F00D; s_rlast = 1'b1;
    #1;
    chk("t2_ifu_rdata", 64'(ifu_rdata), 64'(32'h0BAD_F00D));
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;

    // LSU byte store, AW accepted two cycles before W
    lsu_awvalid = 1'b1; lsu_awaddr = 32'h0000_0003; lsu_awsize = 3'd0;
    lsu_wvalid = 1'b1; lsu_wdata = 32'hAB00_0000; lsu_wstrb = 4'b1000; lsu_wlast = 1'b1;
    lsu_bready = 1'b1; s_awready = 1'b1; s_wready = 1'b0;
    tick(); #1;
    chk("t3_s_awvalid", 64'(s_awvalid), 64'(1'b1));
    chk("t3_s_awaddr", 64'(s_awaddr), 64'(32'h0000_0003));
    chk("t3_lsu_awready", 64'(lsu_awready), 64'(1'b1));
    chk("t3_s_wstrb", 64'(s_wstrb), 64'(4'b1000));
    chk("t3_lsu_wready0", 64'(lsu_wready), 64'(1'b0));
    tick();
    lsu_awvalid = 1'b0;
    #1;
    chk("t3_s_awvalid_done", 64'(s_awvalid), 64'(1'b0));
    tick();
    s_wready = 1'b1;
    #1;
    chk("t3_lsu_wready", 64'(lsu_wready), 64'(1'b1));
    chk("t3_s_wdata", 64'(s_wdata), 64'(32'hAB00_0000));
    tick();
    lsu_wvalid = 1'b0; lsu_wlast = 1'b0; s_wready = 1'b0;
    s_bvalid = 1'b1; s_bresp = 2'b10;
    #1;
    chk("t3_lsu_bvalid", 64'(lsu_bvalid), 64'(1'b1));
    chk("t3_lsu_bresp", 64'(lsu_bresp), 64'(2'b10));
    chk("t3_s_bready", 64'(s_bready), 64'(1'b1));
    tick();
    s_bvalid = 1'b0; s_bresp = 2'b00;
    #1;
    chk("t3_idle_busy", 64'(arb_busy), 64'(1'b0));

    // IFU 4-beat burst; LSU read arrives mid-burst and waits
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0100; ifu_arlen = 8'd3;
    tick(); #1;
    chk("t4_s_arlen", 64'(s_arlen), 64'(8'd3));
    lsu_arvalid = 1'b1; lsu_araddr = 32'h0000_0200;
    tick();
    ifu_arvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_rvalid = 1'b1; s_rdata = 32'h0000_0010 + 32'(i); s_rlast = (i == 3);
      #1;
      chk("t4_ifu_rdata", 64'(ifu_rdata), 64'(32'h0000_0010 + 32'(i)));
      chk("t4_lsu_arready_held", 64'(lsu_arready), 64'(1'b0));
      tick();
    end
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1;
    chk("t4_idle_busy", 64'(arb_busy), 64'(1'b0));
    tick(); #1;
    chk("t4_lsu_arready", 64'(lsu_arready), 64'(1'b1));
    chk("t4_s_araddr", 64'(s_araddr), 64'(32'h0000_0200));
    tick();
    lsu_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h5555_AAAA; s_rlast = 1'b1;
    #1;
    chk("t4_lsu_rdata", 64'(lsu_rdata), 64'(32'h5555_AAAA));
    tick();
    s_rvalid = 1'b0; s_rlast = 1'b0;

    // Watchdog: slave never responds
    ifu_arvalid = 1'b1; ifu_arlen = 8'd0;
    tick();
    tick();
    ifu_arvalid = 1'b0;
    repeat (14) tick();
    #1;
    chk("t5_busy_c16", 64'(arb_busy), 64'(1'b1));
    chk("t5_timeout_c16", 64'(arb_timeout), 64'(1'b0));
    tick(); #1;
    chk("t5_timeout", 64'(arb_timeout), 64'(1'b1));
    chk("t5_busy", 64'(arb_busy), 64'(1'b0));
    tick(); #1;
    chk("t5_timeout_sticky", 64'(arb_timeout), 64'(1'b1));

    // Reset in the middle of a burst
    ifu_arvalid = 1'b1; ifu_arlen = 8'd3;
    tick();
    tick();
    ifu_arvalid = 1'b0;
    s_rvalid = 1'b1; s_rdata = 32'h7777_0000; s_rlast = 1'b0;
    #1;
    chk("t6_beat0", 64'(ifu_rvalid), 64'(1'b1));
    tick();
    reset = 1'b1; s_rvalid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    chk("t6_busy", 64'(arb_busy), 64'(1'b0));
    chk("t6_timeout", 64'(arb_timeout), 64'(1'b0));
    chk("t6_ifu_rdata", 64'(ifu_rdata), 64'(32'h0));
    chk("t6_s_rready", 64'(s_rready), 64'(1'b0));

    // Round-robin instance: continuous IFU+LSU reads alternate LSU, IFU, LSU, IFU
    r_s_arready = 1'b1;
    exp_lsu = 4'b0101;
    ifu_arvalid = 1'b1; lsu_arvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
      chk("rr_lsu_grant", 64'(r_lsu_arready), 64'(exp_lsu[i]));
      chk("rr_ifu_grant", 64'(r_ifu_arready), 64'(!exp_lsu[i]));
      tick();
      r_s_rvalid = 1'b1; r_s_rlast = 1'b1; r_s_rdata = 32'hC0DE_0000 + 32'(i);
      #1;
      chk("rr_lsu_rvalid", 64'(r_lsu_rvalid), 64'(exp_lsu[i]));
      chk("rr_ifu_rvalid", 64'(r_ifu_rvalid), 64'(!exp_lsu[i]));
      tick();
      r_s_rvalid = 1'b0; r_s_rlast = 1'b0;
      #1;
      chk("rr_idle", 64'(r_arb_busy), 64'(1'b0));
    end
    ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
